fabric_cfg_sequencer: RTL and testbench



---
 rtl/fabric_cfg_pkg.sv | 42 ++++
 rtl/cfg_piso.sv | 48 ++++
 rtl/fabric_cfg_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fabric_cfg_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fabric_cfg_pkg
//  Purpose  : Shared types and helpers for the CLB fabric configuration
//             sequencer: FSM state encoding, default widths and a
//             column-index to one-hot strobe decode.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package fabric_cfg_pkg;

  localparam int NUM_COLS_DEF = 3;
  localparam int WORD_W_DEF   = 32;
  localparam int LEN_W_DEF    = 16;
  localparam int COL_W_DEF    = 2;

  // Upper bound on the column count the one-hot helper can express.
  localparam int MAX_COLS = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SET   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // One-hot decode of a column index. An index outside the fabric yields
  // all zeros, so an out-of-range column can never raise a strobe.
  function automatic logic [MAX_COLS-1:0] col_onehot(input int unsigned col,
                                                     input int unsigned num_cols);
    logic [MAX_COLS-1:0] oh;
    oh = '0;
    if (col < num_cols && col < MAX_COLS) begin
      oh = {{(MAX_COLS-1){1'b0}}, 1'b1} << col;
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_piso.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_piso
//  Purpose  : WORD_W-bit parallel-load / serial-out shift register with a
//             bit counter. Bit 0 of the loaded word is presented first.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             load, din       - capture din and restart the bit count
//             shift           - shift right one place, advance bit count
//             serial_out      - current LSB of the shift register
//             last            - bit count is at WORD_W-1 (final bit)
//  Revision : 1.0  initial release
// ============================================================================
module cfg_piso #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              serial_out,
  output logic              last
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  bit_cnt;

  // Load wins over shift; the counter wraps naturally after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= din;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= sr >> 1;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign serial_out = sr[0];
  assign last       = (bit_cnt == CNT_W'(WORD_W - 1));

endmodule
`default_nettype wire

// File: rtl/fabric_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fabric_cfg_sequencer
//  Purpose  : Serialises configuration words into the per-column shift/set
//             chains of the CLB fabric. A column-load command selects the
//             column and word count; each word is shifted LSB-first, one
//             bit per cycle, and a single set pulse latches the column.
//  Ports    : clk, rst            - fabric clock, synchronous active-high reset
//             cmd_valid/ready     - command handshake
//             cmd_col, cmd_len    - target column, number of words
//             data_valid/ready    - config word handshake
//             data_word           - config word, bit 0 shifted first
//             cfg_bit             - serial config data shared by all columns
//             shift_out, set_out  - per-column shift / set strobes
//             cen                 - configuration enable
//             busy, done, err     - status (done/err are one-cycle pulses)
//  Revision : 1.0  initial release
// ============================================================================
module fabric_cfg_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int WORD_W   = WORD_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int COL_W    = COL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COL_W-1:0]    cmd_col,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [WORD_W-1:0]   data_word,
  output logic                cfg_bit,
  output logic [NUM_COLS-1:0] shift_out,
  output logic [NUM_COLS-1:0] set_out,
  output logic                cen,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic [LEN_W-1:0] words_left;
  logic [LEN_W-1:0] words_nxt;
  logic             shifting;

  logic             piso_load;
  logic             piso_shift;
  logic             piso_bit;
  logic             piso_last;

  logic [MAX_COLS-1:0] col_oh_wide;
  logic [NUM_COLS-1:0] col_oh;

  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load       (piso_load),
    .shift      (piso_shift),
    .din        (data_word),
    .serial_out (piso_bit),
    .last       (piso_last)
  );

  // -------------------------------------------------------------------------
  // Next-state logic. Outputs are decoded from the next state and registered
  // alongside it, so every output is a Moore function of registered state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    words_nxt  = words_left;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          col_nxt   = cmd_col;
          words_nxt = cmd_len;
          if (32'(cmd_col) >= NUM_COLS) begin
            state_nxt = S_ERR;
          end else if (cmd_len == '0) begin
            state_nxt = S_SET;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (data_valid) begin
          piso_load = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        piso_shift = 1'b1;
        if (piso_last) begin
          words_nxt = words_left - LEN_W'(1);
          // words_left is checked before decrementing, so a full-scale
          // length counts down to zero without wrapping.
          state_nxt = (words_left == LEN_W'(1)) ? S_SET : S_LOAD;
        end
      end
      S_SET:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decode of the column that will be active next cycle; an out-of-range
  // column decodes to all zeros.
  assign col_oh_wide = col_onehot(32'(col_nxt), NUM_COLS);
  assign col_oh      = col_oh_wide[NUM_COLS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      words_left <= '0;
      shifting   <= 1'b0;
      cmd_ready  <= 1'b1;
      data_ready <= 1'b0;
      cen        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      shift_out  <= '0;
      set_out    <= '0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      words_left <= words_nxt;
      shifting   <= (state_nxt == S_SHIFT);
      cmd_ready  <= (state_nxt == S_IDLE);
      data_ready <= (state_nxt == S_LOAD);
      cen        <= (state_nxt == S_LOAD) || (state_nxt == S_SHIFT) ||
                    (state_nxt == S_SET);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      err        <= (state_nxt == S_ERR);
      shift_out  <= (state_nxt == S_SHIFT) ? col_oh : '0;
      set_out    <= (state_nxt == S_SET)   ? col_oh : '0;
    end
  end

  // The shift register is loaded on the same edge that enters SHIFT, so its
  // LSB is already the first bit when the strobe rises.
  assign cfg_bit = shifting & piso_bit;

endmodule
`default_nettype wire

// File: tb/tb_fabric_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fabric_cfg_sequencer
//  Purpose  : Self-checking bench for fabric_cfg_sequencer. Expected serial
//             streams, strobe masks, counts and latencies come from a
//             transaction-level model of the command semantics.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_fabric_cfg_sequencer;

  localparam int NCOLS = 3;
  localparam int WW    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_col;
  logic [15:0] cmd_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_word;
  logic        cfg_bit;
  logic [2:0]  shift_out;
  logic [2:0]  set_out;
  logic        cen;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] words[$];

  always #5 clk = ~clk;

  fabric_cfg_sequencer #(
    .NUM_COLS (NCOLS),
    .WORD_W   (WW),
    .LEN_W    (16),
    .COL_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_col    (cmd_col),
    .cmd_len    (cmd_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_word  (data_word),
    .cfg_bit    (cfg_bit),
    .shift_out  (shift_out),
    .set_out    (set_out),
    .cen        (cen),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_data_ready"}, data_ready, 0);
    check_eq({tag, "_strobes"}, {26'd0, shift_out, set_out}, 0);
    check_eq({tag, "_status"}, {28'd0, cen, busy, done, err}, 0);
  endtask

  // Issue one command and follow it to its done/err pulse. The model: a
  // legal column sees len*WW shift strobes carrying the words LSB-first,
  // then exactly one set strobe, then done; an illegal column sees only err.
  task automatic run_cmd(input int c, input int len, input int gmin, input int gmax,
                         input bit chk_lat);
    bit          exp_bits[$];
    logic [2:0]  mask;
    bit          is_err;
    bit          finished;
    bit          hs_d;
    int          nshift, nset, ndone, nerr, cyc, widx, gap;
    nshift = 0; nset = 0; ndone = 0; nerr = 0; cyc = 0; widx = 0;
    finished = 1'b0;
    is_err = (c >= NCOLS);
    mask = '0;
    if (!is_err) begin
      mask[c] = 1'b1;
      for (int w = 0; w < len; w++)
        for (int b = 0; b < WW; b++)
          exp_bits.push_back(words[w][b]);
    end

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_col    = 2'(c);
    cmd_len    = 16'(len);
    data_valid = 1'b0;
    check_eq("cmd_ready_before_cmd", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    gap = int'($urandom_range(gmax, gmin));

    for (int k = 0; k < 5000 && !finished; k++) begin
      cyc++;
      check_eq("strobe_exclusive", {31'd0, $onehot0({shift_out, set_out})}, 1);
      if (shift_out != 3'b000) begin
        check_eq("shift_mask", shift_out, mask);
        if (nshift < exp_bits.size())
          check_eq("cfg_bit", cfg_bit, exp_bits[nshift]);
        else
          check_eq("extra_shift", nshift, exp_bits.size());
        nshift++;
      end
      if (set_out != 3'b000) begin
        check_eq("set_mask", set_out, mask);
        check_eq("shifts_before_set", nshift, exp_bits.size());
        nset++;
      end
      if (done) begin ndone++; finished = 1'b1; end
      if (err)  begin nerr++;  finished = 1'b1; end
      if (!finished) begin
        @(negedge clk);
        if (!is_err && widx < len) begin
          if (gap > 0) begin
            gap--;
            data_valid = 1'b0;
            data_word  = $urandom;
          end else begin
            data_valid = 1'b1;
            data_word  = words[widx];
          end
        end else begin
          data_valid = 1'b0;
          data_word  = $urandom;
        end
        hs_d = data_valid && data_ready;
        @(posedge clk);
        #1;
        if (hs_d) begin
          widx++;
          gap = int'($urandom_range(gmax, gmin));
        end
      end
    end
    data_valid = 1'b0;

    check_eq("cmd_finished", finished, 1);
    if (is_err) begin
      check_eq("err_count", nerr, 1);
      check_eq("err_latency", cyc, 1);
      check_eq("err_no_shift", nshift, 0);
      check_eq("err_no_set", nset, 0);
    end else begin
      check_eq("done_count", ndone, 1);
      check_eq("shift_total", nshift, len * WW);
      check_eq("set_count", nset, 1);
      if (chk_lat) check_eq("done_latency", cyc, len * (WW + 1) + 2);
    end

    @(posedge clk);
    #1;
    check_idle_outputs("back_to_idle");
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_col    = '0;
    cmd_len    = '0;
    data_valid = 1'b0;
    data_word  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // data_valid in IDLE must not be accepted.
    data_valid = 1'b1;
    data_word  = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_data_ready", data_ready, 0);
      check_eq("idle_busy", busy, 0);
    end
    @(negedge clk);
    data_valid = 1'b0;

    // Single word into column 1.
    words.delete();
    words.push_back(32'h0000_0005);
    run_cmd(1, 1, 0, 0, 1'b1);

    // Three words into column 2 with 5-cycle data gaps.
    words.delete();
    words.push_back(32'hFFFF_FFFF);
    words.push_back(32'h0000_0000);
    words.push_back(32'hA5A5_A5A5);
    run_cmd(2, 3, 5, 5, 1'b0);

    // Column outside the fabric.
    words.delete();
    words.push_back($urandom);
    run_cmd(3, 1, 0, 0, 1'b0);

    // Zero-length command: latch only.
    words.delete();
    run_cmd(0, 0, 0, 0, 1'b1);

    // Reset during shift cycle 10 of a two-word load.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_col   = 2'd1;
    cmd_len   = 16'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    data_valid = 1'b1;
    data_word  = $urandom;
    @(posedge clk);
    #1;
    check_eq("midrst_shifting", shift_out, 3'b010);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("midrst_no_set", set_out, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;

    words.delete();
    words.push_back($urandom);
    words.push_back($urandom);
    run_cmd(1, 2, 0, 0, 1'b1);

    // Randomised commands, including occasional illegal columns.
    for (int t = 0; t < 8; t++) begin
      int c, len, gmax;
      c    = int'($urandom_range(3, 0));
      len  = int'($urandom_range(3, 0));
      gmax = int'($urandom_range(3, 0));
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      run_cmd(c, len, 0, gmax, gmax == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
